// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared UART receive-buffer types and default sizing.
// The default timeout is four 10-bit character times at the configured bit period.
package uart_rx_fifo_pkg;
    localparam int UART_DW = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_THRESH = 8;
    localparam int CLK_PER_BIT = 217;
    localparam int DEF_TIMEOUT = 4 * 10 * CLK_PER_BIT;
    typedef logic [UART_DW-1:0] byte_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte-in / CPU-read / status bundle of the UART receive FIFO.
// master drives the strobes (UART_RX plus AHB side); slave is the FIFO itself.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int AW = 4
);
    byte_t rx_data;
    logic rx_valid;
    logic rd_en;
    logic flush;
    logic ovf_clr;
    byte_t rd_data;
    logic empty;
    logic full;
    logic [AW:0] level;
    logic overflow;
    logic timeout;
    logic irq;
    modport master (
        output rx_data, rx_valid, rd_en, flush, ovf_clr,
        input rd_data, empty, full, level, overflow, timeout, irq
    );
    modport slave (
        input rx_data, rx_valid, rd_en, flush, ovf_clr,
        output rd_data, empty, full, level, overflow, timeout, irq
    );
endinterface

// File: rtl/uart_rx_fifo_mem.sv
// sync_fifo_mem: DEPTH x byte register array, synchronous write, asynchronous read.
// The combinational read lets the head byte fall through to rd_data.
module sync_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW = $clog2(DEPTH)
) (
    input logic clk,
    input logic we,
    input logic [AW-1:0] wr_ptr,
    input byte_t wr_data,
    input logic [AW-1:0] rd_ptr,
    output byte_t rd_data
);
    byte_t mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[wr_ptr] <= wr_data;
    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive FIFO driving the UART IRQ on level, overflow or idle timeout.
// Idle timeout is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW = $clog2(DEPTH),
    parameter int THRESH = DEF_THRESH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT
) (
    input logic clk,
    input logic rst,
    uart_rx_fifo_if.slave bus
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] level;
    logic full, empty, push, pop, ovf_set, overflow, timeout;
    assign full = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    // a full FIFO still accepts a byte when the head is popped in the same cycle
    assign push = bus.rx_valid && (!full || bus.rd_en) && !bus.flush;
    assign pop = bus.rd_en && !empty && !bus.flush;
    assign ovf_set = bus.rx_valid && full && !bus.rd_en && !bus.flush;
    sync_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk(clk),
        .we(push),
        .wr_ptr(wr_ptr),
        .wr_data(bus.rx_data),
        .rd_ptr(rd_ptr),
        .rd_data(bus.rd_data)
    );
    always_ff @(posedge clk)
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) level <= push ? level + 1'b1 : level - 1'b1;
        end
    always_ff @(posedge clk)
        if (rst) overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (bus.ovf_clr) overflow <= 1'b0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] idle_cnt;
    // counter saturates at TIMEOUT_CYC-1; the flag follows one cycle later
    always_ff @(posedge clk)
        if (rst || push || pop || bus.flush) begin
            idle_cnt <= '0;
            timeout <= 1'b0;
        end else if (empty) idle_cnt <= '0;
        else if (idle_cnt == TW'(TIMEOUT_CYC - 1)) timeout <= 1'b1;
        else idle_cnt <= idle_cnt + 1'b1;
`else
    assign timeout = 1'b0;
`endif
    assign bus.empty = empty;
    assign bus.full = full;
    assign bus.level = level;
    assign bus.overflow = overflow;
    assign bus.timeout = timeout;
    assign bus.irq = (level >= (AW+1)'(THRESH)) | overflow | timeout;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed plus random checks of uart_rx_fifo against a queue model.
// Build with UART_RX_FIFO_TIMEOUT_EN to exercise the idle timeout.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int THRESH = 8;
    localparam int TC = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    byte_t q[$];
    logic m_ovf = 1'b0;
    int m_idle = 0;
    uart_rx_fifo_if #(.AW(AW)) bus ();
    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .THRESH(THRESH), .TIMEOUT_CYC(TC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_to();
`ifdef UART_RX_FIFO_TIMEOUT_EN
        return m_idle >= TC;
`else
        return 1'b0;
`endif
    endfunction

    task automatic verify();
        chk("level", 32'(bus.level), 32'(q.size()));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("timeout", 32'(bus.timeout), 32'(m_to()));
        chk("irq", 32'(bus.irq), 32'((q.size() >= THRESH) || m_ovf || m_to()));
        if (q.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(q[0]));
    endtask

    task automatic step(input logic v, input byte_t d, input logic r, input logic f, input logic c);
        int n;
        logic did_push, did_pop;
        bus.rx_valid = v;
        bus.rx_data = d;
        bus.rd_en = r;
        bus.flush = f;
        bus.ovf_clr = c;
        @(posedge clk);
        n = q.size();
        did_pop = !f && r && n > 0;
        did_push = !f && v && (n < DEPTH || r);
        if (f) q.delete();
        if (did_pop) void'(q.pop_front());
        if (did_push) q.push_back(d);
        if (v && !f && n == DEPTH && !r) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        // idle time counts only while bytes are waiting and nothing moves
        if (f || did_push || did_pop || n == 0) m_idle = 0;
        else m_idle++;
        #1;
        verify();
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data = '0;
        bus.rd_en = 1'b0;
        bus.flush = 1'b0;
        bus.ovf_clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_idle = 0;
        verify();
    endtask

    task automatic push(input byte_t d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        chk("reset_empty", 32'(bus.empty), 32'd1);
        chk("reset_irq", 32'(bus.irq), 32'd0);

        push(8'h41);
        push(8'h42);
        push(8'h43);
        chk("abc_level", 32'(bus.level), 32'd3);
        chk("abc_head", 32'(bus.rd_data), 32'h41);
        pop();
        chk("abc_pop1", 32'(bus.rd_data), 32'h42);
        pop();
        chk("abc_pop2", 32'(bus.rd_data), 32'h43);
        pop();
        chk("abc_empty", 32'(bus.empty), 32'd1);
        pop();

        for (int i = 0; i <= 16; i++) push(byte_t'(i));
        chk("ovf_full", 32'(bus.full), 32'd1);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_order", 32'(bus.rd_data), 32'(i));
            pop();
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(bus.overflow), 32'd0);

        for (int i = 0; i < 16; i++) push(byte_t'(8'h20 + i));
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        chk("fullrw_level", 32'(bus.level), 32'd16);
        chk("fullrw_ovf", 32'(bus.overflow), 32'd0);
        repeat (15) pop();
        chk("fullrw_last", 32'(bus.rd_data), 32'hAA);
        pop();

        for (int i = 0; i < 7; i++) push(byte_t'(8'h60 + i));
        chk("thr_below", 32'(bus.irq), 32'd0);
        push(8'h67);
        chk("thr_at", 32'(bus.irq), 32'd1);
        pop();
        chk("thr_drop", 32'(bus.irq), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            push(byte_t'(8'h80 + i));
            chk("wrap_data", 32'(bus.rd_data), 32'(8'h80 + i));
            pop();
        end
        for (int i = 0; i < 17; i++) push(byte_t'(8'hC0 + i));
        step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        chk("flush_level", 32'(bus.level), 32'd0);
        chk("flush_empty", 32'(bus.empty), 32'd1);
        chk("flush_ovf", 32'(bus.overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        push(8'h77);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        repeat (TC - 1) idle();
        chk("to_before", 32'(bus.timeout), 32'd0);
        idle();
        chk("to_set", 32'(bus.timeout), 32'd1);
        chk("to_irq", 32'(bus.irq), 32'd1);
        pop();
        chk("to_clr", 32'(bus.timeout), 32'd0);
        chk("to_irq_clr", 32'(bus.irq), 32'd0);
`else
        repeat (TC + 8) idle();
        chk("to_off", 32'(bus.timeout), 32'd0);
        pop();
`endif

        for (int i = 0; i < 600; i++) begin
            int rd_pct;
            rd_pct = ((i / 100) % 2 == 0) ? 25 : 70;
            step($urandom_range(0, 99) < 55, byte_t'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < rd_pct, $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 3) repeat ($urandom_range(1, TC + 4)) idle();
        end

        for (int i = 0; i < 5; i++) push(byte_t'(8'hE0 + i));
        do_reset();
        chk("midrst_level", 32'(bus.level), 32'd0);
        push(8'h99);
        chk("postrst_head", 32'(bus.rd_data), 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
